// File: rtl/ifu_fetch_if.sv
// rtl/ifu_fetch_if.sv - IFU fetch bundle: EXU handshake, PC unit, flush and instruction bus signals (optional IFU_BUS_ERR_EN error pins)
interface ifu_fetch_if #(
    parameter int PC_SIZE = 32
);
    logic [PC_SIZE-1:0] ifu_i_pcnxt;
    logic               ifu_i_flush;
    logic [PC_SIZE-1:0] ifu_i_flush_pc;
    logic               ifu_o_valid;
    logic               ifu_i_ready;
    logic [31:0]        ifu_o_instr;
    logic [PC_SIZE-1:0] ifu_o_pc;
    logic               ifu_o_rv32;
    logic               ifu_o_cmd_valid;
    logic               ifu_i_cmd_ready;
    logic [PC_SIZE-1:0] ifu_o_cmd_addr;
    logic               ifu_i_rsp_valid;
    logic               ifu_o_rsp_ready;
    logic [31:0]        ifu_i_rsp_rdata;
`ifdef IFU_BUS_ERR_EN
    logic               ifu_i_rsp_err;
    logic               ifu_o_buserr;

    modport master (
        input  ifu_i_pcnxt, ifu_i_flush, ifu_i_flush_pc, ifu_i_ready,
        input  ifu_i_cmd_ready, ifu_i_rsp_valid, ifu_i_rsp_rdata, ifu_i_rsp_err,
        output ifu_o_valid, ifu_o_instr, ifu_o_pc, ifu_o_rv32,
        output ifu_o_cmd_valid, ifu_o_cmd_addr, ifu_o_rsp_ready, ifu_o_buserr
    );

    modport slave (
        output ifu_i_pcnxt, ifu_i_flush, ifu_i_flush_pc, ifu_i_ready,
        output ifu_i_cmd_ready, ifu_i_rsp_valid, ifu_i_rsp_rdata, ifu_i_rsp_err,
        input  ifu_o_valid, ifu_o_instr, ifu_o_pc, ifu_o_rv32,
        input  ifu_o_cmd_valid, ifu_o_cmd_addr, ifu_o_rsp_ready, ifu_o_buserr
    );
`else
    modport master (
        input  ifu_i_pcnxt, ifu_i_flush, ifu_i_flush_pc, ifu_i_ready,
        input  ifu_i_cmd_ready, ifu_i_rsp_valid, ifu_i_rsp_rdata,
        output ifu_o_valid, ifu_o_instr, ifu_o_pc, ifu_o_rv32,
        output ifu_o_cmd_valid, ifu_o_cmd_addr, ifu_o_rsp_ready
    );

    modport slave (
        output ifu_i_pcnxt, ifu_i_flush, ifu_i_flush_pc, ifu_i_ready,
        output ifu_i_cmd_ready, ifu_i_rsp_valid, ifu_i_rsp_rdata,
        input  ifu_o_valid, ifu_o_instr, ifu_o_pc, ifu_o_rv32,
        input  ifu_o_cmd_valid, ifu_o_cmd_addr, ifu_o_rsp_ready
    );
`endif
endinterface

// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - instruction fetch engine: word fetches, 16/32-bit assembly incl. split 32-bit, flush/drain (optional IFU_BUS_ERR_EN)
module ifu_fetch #(
    parameter int                 PC_SIZE  = 32,
    parameter logic [PC_SIZE-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    ifu_fetch_if.master   bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_RSP, S_CMD2, S_RSP2, S_OUT, S_DRAIN
    } state_t;

    state_t             state, n_state;
    logic [PC_SIZE-1:0] fetch_pc, n_fetch_pc;
    logic [15:0]        half, n_half;
    // In DRAIN: 1 while the abandoned command is still waiting for cmd_ready
    logic               drain_cmd, n_drain_cmd;
    logic [PC_SIZE-1:0] cmd_addr_q, n_cmd_addr;
    logic [31:0]        instr_q, n_instr;
    logic [PC_SIZE-1:0] pc_q, n_pc;
    logic               rv32_q, n_rv32;
    logic               cmd_valid_q, rsp_ready_q, o_valid_q;
    logic               n_cmd_valid, n_rsp_ready, n_o_valid;
    logic               cmd_fire, rsp_fire;
    logic [31:0]        rdata;
`ifdef IFU_BUS_ERR_EN
    logic               buserr_q, n_buserr;
`endif

    function automatic logic [PC_SIZE-1:0] word_align(input logic [PC_SIZE-1:0] a);
        return {a[PC_SIZE-1:2], 2'b00};
    endfunction

    assign cmd_fire = cmd_valid_q & bus.ifu_i_cmd_ready;
    assign rsp_fire = rsp_ready_q & bus.ifu_i_rsp_valid;
    assign rdata    = bus.ifu_i_rsp_rdata;

    // Next-state, next-PC and next-output decode; flush takes priority over the EXU handshake
    always_comb begin
        n_state     = state;
        n_fetch_pc  = fetch_pc;
        n_half      = half;
        n_drain_cmd = drain_cmd;
        n_instr     = instr_q;
        n_pc        = pc_q;
        n_rv32      = rv32_q;
        n_cmd_addr  = cmd_addr_q;
`ifdef IFU_BUS_ERR_EN
        n_buserr    = buserr_q;
`endif
        case (state)
            S_IDLE: begin
                if (bus.ifu_i_flush) n_fetch_pc = bus.ifu_i_flush_pc;
                n_state = S_CMD;
            end
            S_CMD, S_CMD2: begin
                if (bus.ifu_i_flush) begin
                    // The command cannot be retracted; finish it in DRAIN
                    n_fetch_pc  = bus.ifu_i_flush_pc;
                    n_state     = S_DRAIN;
                    n_drain_cmd = !cmd_fire;
                end else if (cmd_fire) begin
                    n_state = (state == S_CMD) ? S_RSP : S_RSP2;
                end
            end
            S_RSP, S_RSP2: begin
                if (bus.ifu_i_flush) begin
                    n_fetch_pc = bus.ifu_i_flush_pc;
                    if (rsp_fire) begin
                        n_state = S_CMD;
                    end else begin
                        n_state     = S_DRAIN;
                        n_drain_cmd = 1'b0;
                    end
                end else if (rsp_fire) begin
                    n_pc = fetch_pc;
`ifdef IFU_BUS_ERR_EN
                    n_buserr = 1'b0;
                    if (bus.ifu_i_rsp_err) begin
                        n_instr  = '0;
                        n_rv32   = 1'b1;
                        n_buserr = 1'b1;
                        n_state  = S_OUT;
                    end else
`endif
                    if (state == S_RSP2) begin
                        n_instr = {rdata[15:0], half};
                        n_rv32  = 1'b1;
                        n_state = S_OUT;
                    end else if (!fetch_pc[1]) begin
                        n_instr = rdata;
                        n_rv32  = (rdata[1:0] == 2'b11);
                        n_state = S_OUT;
                    end else if (rdata[17:16] != 2'b11) begin
                        n_instr = {16'h0, rdata[31:16]};
                        n_rv32  = 1'b0;
                        n_state = S_OUT;
                    end else begin
                        // Upper half starts a 32-bit instruction; fetch the next word
                        n_half  = rdata[31:16];
                        n_state = S_CMD2;
                    end
                end
            end
            S_OUT: begin
                if (bus.ifu_i_flush) begin
                    n_fetch_pc = bus.ifu_i_flush_pc;
                    n_state    = S_CMD;
                end else if (bus.ifu_i_ready) begin
                    n_fetch_pc = bus.ifu_i_pcnxt;
                    n_state    = S_CMD;
                end
            end
            S_DRAIN: begin
                if (bus.ifu_i_flush) n_fetch_pc = bus.ifu_i_flush_pc;
                if (drain_cmd) begin
                    if (cmd_fire) n_drain_cmd = 1'b0;
                end else if (rsp_fire) begin
                    n_state = S_CMD;
                end
            end
            default: n_state = S_IDLE;
        endcase

        if (n_state == S_CMD)
            n_cmd_addr = word_align(n_fetch_pc);
        else if (n_state == S_CMD2)
            n_cmd_addr = word_align(fetch_pc + PC_SIZE'(4));

        n_cmd_valid = (n_state == S_CMD) || (n_state == S_CMD2) ||
                      ((n_state == S_DRAIN) && n_drain_cmd);
        n_rsp_ready = (n_state == S_RSP) || (n_state == S_RSP2) ||
                      ((n_state == S_DRAIN) && !n_drain_cmd);
        n_o_valid   = (n_state == S_OUT);
    end

    // FSM state, fetch PC and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            fetch_pc    <= RESET_PC;
            half        <= '0;
            drain_cmd   <= 1'b0;
            cmd_addr_q  <= '0;
            instr_q     <= '0;
            pc_q        <= RESET_PC;
            rv32_q      <= 1'b0;
            cmd_valid_q <= 1'b0;
            rsp_ready_q <= 1'b0;
            o_valid_q   <= 1'b0;
`ifdef IFU_BUS_ERR_EN
            buserr_q    <= 1'b0;
`endif
        end else begin
            state       <= n_state;
            fetch_pc    <= n_fetch_pc;
            half        <= n_half;
            drain_cmd   <= n_drain_cmd;
            cmd_addr_q  <= n_cmd_addr;
            instr_q     <= n_instr;
            pc_q        <= n_pc;
            rv32_q      <= n_rv32;
            cmd_valid_q <= n_cmd_valid;
            rsp_ready_q <= n_rsp_ready;
            o_valid_q   <= n_o_valid;
`ifdef IFU_BUS_ERR_EN
            buserr_q    <= n_buserr;
`endif
        end
    end

    assign bus.ifu_o_valid     = o_valid_q;
    assign bus.ifu_o_instr     = instr_q;
    assign bus.ifu_o_pc        = pc_q;
    assign bus.ifu_o_rv32      = rv32_q;
    assign bus.ifu_o_cmd_valid = cmd_valid_q;
    assign bus.ifu_o_cmd_addr  = cmd_addr_q;
    assign bus.ifu_o_rsp_ready = rsp_ready_q;
`ifdef IFU_BUS_ERR_EN
    assign bus.ifu_o_buserr    = buserr_q;
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// tb/tb_ifu_fetch.sv - scoreboard bench for ifu_fetch: alignment, split fetch, stall, flush/drain, wrap (IFU_BUS_ERR_EN aware)
module tb_ifu_fetch;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ifu_fetch_if #(.PC_SIZE(32)) bif();

    ifu_fetch #(.PC_SIZE(32), .RESET_PC(32'h0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        rv32;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] instr, input logic [31:0] pc, input logic rv32, input logic err);
        exp_t e;
        e.instr = instr; e.pc = pc; e.rv32 = rv32; e.err = err;
        sb.push_back(e);
    endtask

    // Wait for a command, check its address, accept it for one cycle
    task automatic do_cmd(input logic [31:0] addr, input string tag);
        int n = 0;
        while (!bif.ifu_o_cmd_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_cmd_valid"}, 64'(bif.ifu_o_cmd_valid), 64'd1);
        chk({tag, "_cmd_addr"}, 64'(bif.ifu_o_cmd_addr), 64'(addr));
        bif.ifu_i_cmd_ready = 1'b1;
        @(negedge clk);
        bif.ifu_i_cmd_ready = 1'b0;
    endtask

    // Present one response after lat idle cycles
    task automatic do_rsp(input logic [31:0] data, input logic err, input int lat, input string tag);
        int n = 0;
        repeat (lat) @(negedge clk);
        bif.ifu_i_rsp_valid = 1'b1;
        bif.ifu_i_rsp_rdata = data;
`ifdef IFU_BUS_ERR_EN
        bif.ifu_i_rsp_err   = err;
`else
        if (err) $display("[TB] bus error stimulus requires IFU_BUS_ERR_EN");
`endif
        while (!bif.ifu_o_rsp_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_rsp_ready"}, 64'(bif.ifu_o_rsp_ready), 64'd1);
        @(negedge clk);
        bif.ifu_i_rsp_valid = 1'b0;
`ifdef IFU_BUS_ERR_EN
        bif.ifu_i_rsp_err   = 1'b0;
`endif
    endtask

    // Wait for an instruction, compare to scoreboard, optionally stall, then accept with pcnxt
    task automatic exu_take(input logic [31:0] pcnxt, input int stall, input string tag);
        int   n = 0;
        exp_t e;
        while (!bif.ifu_o_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, 64'(bif.ifu_o_valid), 64'd1);
        chk({tag, "_sb_nonempty"}, 64'(sb.size() != 0), 64'd1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        for (int i = 0; i <= stall; i++) begin
            if (i == 1) bif.ifu_i_rsp_valid = 1'b1;
            chk({tag, "_instr"}, 64'(bif.ifu_o_instr), 64'(e.instr));
            chk({tag, "_pc"}, 64'(bif.ifu_o_pc), 64'(e.pc));
            chk({tag, "_rv32"}, 64'(bif.ifu_o_rv32), 64'(e.rv32));
`ifdef IFU_BUS_ERR_EN
            chk({tag, "_buserr"}, 64'(bif.ifu_o_buserr), 64'(e.err));
`endif
            chk({tag, "_no_cmd"}, 64'(bif.ifu_o_cmd_valid), 64'd0);
            chk({tag, "_no_rsp_ready"}, 64'(bif.ifu_o_rsp_ready), 64'd0);
            if (i < stall) begin
                @(negedge clk);
                chk({tag, "_stall_valid"}, 64'(bif.ifu_o_valid), 64'd1);
            end
        end
        bif.ifu_i_rsp_valid = 1'b0;
        bif.ifu_i_pcnxt = pcnxt;
        bif.ifu_i_ready = 1'b1;
        @(negedge clk);
        bif.ifu_i_ready = 1'b0;
    endtask

    initial begin
        int n;
        bif.ifu_i_pcnxt     = '0;
        bif.ifu_i_flush     = 1'b0;
        bif.ifu_i_flush_pc  = '0;
        bif.ifu_i_ready     = 1'b0;
        bif.ifu_i_cmd_ready = 1'b0;
        bif.ifu_i_rsp_valid = 1'b0;
        bif.ifu_i_rsp_rdata = '0;
`ifdef IFU_BUS_ERR_EN
        bif.ifu_i_rsp_err   = 1'b0;
`endif

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_valid", 64'(bif.ifu_o_valid), 64'd0);
        chk("rst_cmd_valid", 64'(bif.ifu_o_cmd_valid), 64'd0);
        chk("rst_rsp_ready", 64'(bif.ifu_o_rsp_ready), 64'd0);
        chk("rst_instr", 64'(bif.ifu_o_instr), 64'd0);
        chk("rst_pc", 64'(bif.ifu_o_pc), 64'd0);
        chk("rst_rv32", 64'(bif.ifu_o_rv32), 64'd0);
        chk("rst_cmd_addr", 64'(bif.ifu_o_cmd_addr), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("first_cmd_timing", 64'(bif.ifu_o_cmd_valid), 64'd1);

        // Aligned 32-bit instruction
        do_cmd(32'h0, "t1");
        push_exp(32'h00000013, 32'h0, 1'b1, 1'b0);
        do_rsp(32'h00000013, 1'b0, 0, "t1");
        exu_take(32'h102, 0, "t1");

        // 16-bit instruction in the upper half
        do_cmd(32'h100, "t2");
        push_exp(32'h00004501, 32'h102, 1'b0, 1'b0);
        do_rsp(32'h45010001, 1'b0, 2, "t2");
        exu_take(32'h106, 0, "t2");

        // 32-bit instruction split across a word boundary, then EXU stall
        do_cmd(32'h104, "t3a");
        do_rsp(32'h00930001, 1'b0, 1, "t3a");
        do_cmd(32'h108, "t3b");
        push_exp(32'h00100093, 32'h106, 1'b1, 1'b0);
        do_rsp(32'h12340010, 1'b0, 0, "t3b");
        exu_take(32'h8, 5, "t3");
        chk("zero_bubble_cmd", 64'(bif.ifu_o_cmd_valid), 64'd1);
        chk("zero_bubble_addr", 64'(bif.ifu_o_cmd_addr), 64'h8);

        // Flush while waiting for a response; stale response 3 cycles later
        do_cmd(32'h8, "t4");
        bif.ifu_i_flush = 1'b1;
        bif.ifu_i_flush_pc = 32'h200;
        @(negedge clk);
        bif.ifu_i_flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t4_drain_valid", 64'(bif.ifu_o_valid), 64'd0);
            chk("t4_drain_no_cmd", 64'(bif.ifu_o_cmd_valid), 64'd0);
            @(negedge clk);
        end
        do_rsp(32'h00000013, 1'b0, 0, "t4_stale");
        chk("t4_stale_valid", 64'(bif.ifu_o_valid), 64'd0);
        do_cmd(32'h200, "t4b");
        push_exp(32'h00A00093, 32'h200, 1'b1, 1'b0);
        do_rsp(32'h00A00093, 1'b0, 0, "t4b");
        exu_take(32'h300, 0, "t4b");

        // Flush while a command is still unaccepted: command must be held
        bif.ifu_i_flush = 1'b1;
        bif.ifu_i_flush_pc = 32'h400;
        @(negedge clk);
        bif.ifu_i_flush = 1'b0;
        chk("t5_held_valid", 64'(bif.ifu_o_cmd_valid), 64'd1);
        do_cmd(32'h300, "t5_old");
        do_rsp(32'h00000013, 1'b0, 1, "t5_stale");
        chk("t5_stale_valid", 64'(bif.ifu_o_valid), 64'd0);
        do_cmd(32'h400, "t5");
        push_exp(32'h00200113, 32'h400, 1'b1, 1'b0);
        do_rsp(32'h00200113, 1'b0, 0, "t5");
        exu_take(32'hFFFFFFFE, 0, "t5");

        // Split fetch at the top of the address space wraps to 0
        do_cmd(32'hFFFFFFFC, "t6a");
        do_rsp(32'h00930000, 1'b0, 0, "t6a");
        do_cmd(32'h0, "t6b");
        push_exp(32'h00100093, 32'hFFFFFFFE, 1'b1, 1'b0);
        do_rsp(32'h00000010, 1'b0, 0, "t6b");
        exu_take(32'h600, 0, "t6");

        // Flush in OUT beats the EXU handshake; pcnxt ignored
        do_cmd(32'h600, "t7");
        do_rsp(32'h00500093, 1'b0, 0, "t7");
        n = 0;
        while (!bif.ifu_o_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t7_valid", 64'(bif.ifu_o_valid), 64'd1);
        bif.ifu_i_flush = 1'b1;
        bif.ifu_i_flush_pc = 32'h502;
        bif.ifu_i_ready = 1'b1;
        bif.ifu_i_pcnxt = 32'h700;
        @(negedge clk);
        bif.ifu_i_flush = 1'b0;
        bif.ifu_i_ready = 1'b0;
        chk("t7_flush_valid", 64'(bif.ifu_o_valid), 64'd0);
        do_cmd(32'h500, "t7b");
`ifdef IFU_BUS_ERR_EN
        // Error response on an upper-half PC: no second fetch
        push_exp(32'h0, 32'h502, 1'b1, 1'b1);
        do_rsp(32'hFFFFFFFF, 1'b1, 0, "t8_err");
`else
        push_exp(32'h00004501, 32'h502, 1'b0, 1'b0);
        do_rsp(32'h45010001, 1'b0, 0, "t8");
`endif
        exu_take(32'h0, 2, "t8");

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
Instruction fetch engine for the IFU. It issues word-aligned fetch commands to the instruction memory bus and assembles 16/32-bit instructions, including 32-bit instructions split across a word boundary. It presents each instruction, its PC and its length to EXU over a valid/ready handshake. It samples the next PC produced by the PC unit on each accepted instruction, and restarts at a flush target on flush.

Parameters:
PC_SIZE, 32, width of PC and bus address
RESET_PC, 0, first fetch address after reset

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
ifu_i_pcnxt  input  PC_SIZE  next PC from PC unit; sampled on EXU handshake
ifu_i_flush  input  1  flush request (branch/irq/exception)
ifu_i_flush_pc  input  PC_SIZE  flush target PC
ifu_o_valid  output  1  instruction valid to EXU
ifu_i_ready  input  1  EXU ready
ifu_o_instr  output  32  instruction; 16-bit instr zero-extended
ifu_o_pc  output  PC_SIZE  PC of ifu_o_instr
ifu_o_rv32  output  1  1 = 32-bit instr, 0 = 16-bit
ifu_o_cmd_valid  output  1  bus command valid
ifu_i_cmd_ready  input  1  bus command ready
ifu_o_cmd_addr  output  PC_SIZE  word-aligned fetch address
ifu_i_rsp_valid  input  1  bus response valid
ifu_o_rsp_ready  output  1  bus response ready
ifu_i_rsp_rdata  input  32  response data

Behaviour:
- Reset (async, rst=1): state IDLE, fetch_pc=RESET_PC, drop=0. All valid/ready outputs 0. instr=0, pc=RESET_PC, rv32=0, cmd_addr=0.
- cmd_addr = {fetch_pc[PC_SIZE-1:2],2'b00} in CMD; fetch_pc+4 (aligned) in CMD2.
- Single outstanding command. rsp_ready=1 only in RSP, RSP2, DRAIN (waiting response).
- States and transitions:
  - IDLE: go to CMD next cycle (first cmd_valid one cycle after reset release).
  - CMD: cmd_valid=1, address stable until cmd_ready; go to RSP on accept.
  - RSP: on rsp_valid:
    - fetch_pc[1]=0: instr=rdata, rv32=(rdata[1:0]==2'b11); go to OUT.
    - fetch_pc[1]=1, rdata[17:16]!=2'b11: instr={16'h0,rdata[31:16]}, rv32=0; go to OUT.
    - fetch_pc[1]=1, rdata[17:16]==2'b11: latch half=rdata[31:16]; go to CMD2.
  - CMD2: as CMD, address fetch_pc+4; go to RSP2.
  - RSP2: on rsp_valid, instr={rdata[15:0],half}, rv32=1; go to OUT.
  - OUT: ifu_o_valid=1; instr/pc/rv32 held stable until ready. On valid&ready: fetch_pc<=ifu_i_pcnxt, go to CMD (cmd_valid next cycle, zero bubble). pc output = fetch_pc of the instruction.
  - DRAIN: complete a pending unaccepted command (cmd_valid held, same address), then accept and discard one response; go to CMD at fetch_pc.
- Flush (any state, priority over EXU handshake; ifu_i_pcnxt ignored that cycle):
  - fetch_pc<=ifu_i_flush_pc; ifu_o_valid=0 next cycle.
  - IDLE/OUT/RSP-with-rsp_valid-same-cycle: go to CMD (response dropped).
  - CMD/CMD2 (accepted or not) or RSP/RSP2 waiting: go to DRAIN. Never retract cmd_valid before cmd_ready.
  - Flush in DRAIN: update fetch_pc only.
- Stale responses never reach ifu_o_valid.
- Response with no outstanding command: ignored (rsp_ready=0).
- PC arithmetic modulo 2^PC_SIZE; fetch_pc+4 wraps.

Optional Feature:
IFU_BUS_ERR_EN:
- Defined: adds input ifu_i_rsp_err (1) and output ifu_o_buserr (1, reset 0). An error response in RSP/RSP2 goes to OUT with instr=0, rv32=1, buserr=1; no second fetch is made.
- Undefined: neither port exists; the error condition is not decoded.

Test Plan:
- Reset release, rsp 0x00000013 → cmd_addr 0x0 one cycle after release; then ifu_o_valid=1, instr=0x00000013, rv32=1, pc=0x0.
- fetch_pc=0x102, word@0x100=0x45010001 → single fetch; instr=0x00004501, rv32=0, pc=0x102.
- fetch_pc=0x106, word@0x104=0x00930001, word@0x108=0x12340010 → cmds 0x104 then 0x108; instr=0x00100093, rv32=1, pc=0x106.
- Flush pc 0x200 while RSP waiting; stale rsp arrives 3 cycles later → valid stays 0 for stale rsp; next cmd_addr=0x200; that instruction presented with pc=0x200.
- OUT with ready=0 for 5 cycles → instr/pc stable, no cmd_valid; ready=1 with pcnxt=0x8 → cmd_addr=0x8 next cycle.
- IFU_BUS_ERR_EN defined, rsp_err=1 → valid=1, buserr=1, instr=0.
